// File: rtl/sram_scheduler.sv
// sram_scheduler: arbitrates the single SRAM port between one-cycle pixel
// read requests from the display side and buffered cell writes from the game
// logic. Reads take priority over writes in IDLE. A write sequence, once it
// has started, always runs to completion. All SRAM-facing strobes, the
// address and the write data are registered.
module sram_scheduler #(
  parameter int unsigned XMAX = 400,
  parameter int unsigned YMAX = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_req,
  input  logic [8:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic [5:0]  pix_data,
  output logic        pix_valid,
  input  logic        wr_valid,
  input  logic [8:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [5:0]  wr_data,
  output logic        wr_ready,
  output logic        wr_drop,
  output logic        overrun,
  output logic        read,
  output logic        write,
  output logic [8:0]  mem_addr_x,
  output logic [8:0]  mem_addr_y,
  output logic [15:0] data_to_write,
  input  logic [15:0] data_in
);

  // Limits widened by one bit so that the unsigned 9-bit coordinate compares
  // stay exact even for a limit of 512.
  localparam logic [9:0] XLIM = 10'(XMAX);
  localparam logic [9:0] YLIM = 10'(YMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_SAMPLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // One-deep read-request latch
  logic        r_rd_pend;
  logic [8:0]  r_rd_x;
  logic [8:0]  r_rd_y;
  logic        r_overrun;

  // Out-of-range flag of the read currently being sequenced
  logic        r_act_oor;

  // One-deep write buffer
  logic        r_wb_full;
  logic [8:0]  r_wb_x;
  logic [8:0]  r_wb_y;
  logic [5:0]  r_wb_data;
  logic        r_wr_drop;

  // Registered SRAM-side and pixel-side outputs
  logic        r_read;
  logic        r_write;
  logic [8:0]  r_addr_x;
  logic [8:0]  r_addr_y;
  logic [15:0] r_dtw;
  logic        r_pix_valid;
  logic [5:0]  r_pix_data;

  // Combinational helpers
  logic        w_idle;
  logic        w_rd_start;
  logic        w_wr_start;
  logic [8:0]  w_sel_x;
  logic [8:0]  w_sel_y;
  logic        w_sel_oor;
  logic        w_wr_ready;
  logic        w_wr_accept;
  logic        w_wr_oor;
  logic        w_read_nxt;
  logic        w_write_nxt;
  logic [8:0]  w_addr_x_nxt;
  logic [8:0]  w_addr_y_nxt;
  logic [15:0] w_dtw_nxt;
  logic        w_unused_data;

  // Only the low six bits of the SRAM bus carry a cell value.
  assign w_unused_data = ^data_in[15:6];

  assign w_idle      = (r_state == S_IDLE);
  // A pending request is older than a new pix_req, so it is served first.
  assign w_sel_x     = r_rd_pend ? r_rd_x : pix_x;
  assign w_sel_y     = r_rd_pend ? r_rd_y : pix_y;
  assign w_sel_oor   = ({1'b0, w_sel_x} >= XLIM) || ({1'b0, w_sel_y} >= YLIM);
  assign w_rd_start  = w_idle && (r_rd_pend || pix_req);
  assign w_wr_start  = w_idle && r_wb_full && !r_rd_pend && !pix_req;

  assign w_wr_ready  = ~r_wb_full & ~rst;
  assign w_wr_accept = wr_valid && w_wr_ready;
  assign w_wr_oor    = ({1'b0, wr_x} >= XLIM) || ({1'b0, wr_y} >= YLIM);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so that all registers
    // update from the same pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection: reads beat writes in IDLE, sequences never preempt
  always_comb begin
    // NOTE: a default assignment at the top of every always_comb keeps each
    // path fully specified, so no latch is inferred.
    w_next_state = S_IDLE;
    unique case (r_state)
      S_IDLE: begin
        if (w_rd_start)      w_next_state = S_RD_SETUP;
        else if (w_wr_start) w_next_state = S_WR_SETUP;
        else                 w_next_state = S_IDLE;
      end
      S_RD_SETUP:  w_next_state = S_RD_SAMPLE;
      S_RD_SAMPLE: w_next_state = S_IDLE;
      S_WR_SETUP:  w_next_state = S_WR_PULSE;
      S_WR_PULSE:  w_next_state = S_WR_HOLD;
      S_WR_HOLD:   w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Output decode: values the registered SRAM outputs take in the next state
  always_comb begin
    w_read_nxt   = 1'b0;
    w_write_nxt  = 1'b0;
    w_addr_x_nxt = r_addr_x;
    w_addr_y_nxt = r_addr_y;
    w_dtw_nxt    = '0;
    unique case (w_next_state)
      S_RD_SETUP: begin
        // Only reachable from IDLE, so the selected request is the one served.
        w_read_nxt   = !w_sel_oor;
        w_addr_x_nxt = w_sel_x;
        w_addr_y_nxt = w_sel_y;
      end
      S_RD_SAMPLE: begin
        w_read_nxt = !r_act_oor;
      end
      S_WR_SETUP: begin
        w_addr_x_nxt = r_wb_x;
        w_addr_y_nxt = r_wb_y;
        w_dtw_nxt    = {10'b0, r_wb_data};
      end
      S_WR_PULSE: begin
        w_write_nxt = 1'b1;
        w_dtw_nxt   = {10'b0, r_wb_data};
      end
      S_WR_HOLD: begin
        w_dtw_nxt = {10'b0, r_wb_data};
      end
      default: begin
        w_read_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs toward the SRAM controller and the pixel consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr_x    <= '0;
      r_addr_y    <= '0;
      r_dtw       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_act_oor   <= 1'b0;
    end else begin
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_addr_x    <= w_addr_x_nxt;
      r_addr_y    <= w_addr_y_nxt;
      r_dtw       <= w_dtw_nxt;
      r_pix_valid <= (r_state == S_RD_SAMPLE);
      if (r_state == S_RD_SAMPLE) begin
        r_pix_data <= r_act_oor ? 6'd0 : data_in[5:0];
      end
      if (w_rd_start) begin
        r_act_oor <= w_sel_oor;
      end
    end
  end

  // Read-request latch and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (pix_req && r_rd_pend) begin
        r_overrun <= 1'b1;
      end
      if (w_rd_start) begin
        r_rd_pend <= 1'b0;
      end else if (pix_req && !r_rd_pend) begin
        r_rd_pend <= 1'b1;
      end
    end
  end

  // Pending-read coordinates, qualified by r_rd_pend
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are only ever read while
    // their valid flag is set, and that flag is reset.
    if (!w_rd_start && pix_req && !r_rd_pend) begin
      r_rd_x <= pix_x;
      r_rd_y <= pix_y;
    end
  end

  // Write-buffer occupancy and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_full <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_accept && w_wr_oor;
      if (w_wr_accept && !w_wr_oor) begin
        r_wb_full <= 1'b1;
      end else if (r_state == S_WR_HOLD) begin
        r_wb_full <= 1'b0;
      end
    end
  end

  // Write-buffer payload, qualified by r_wb_full
  always_ff @(posedge clk) begin
    if (w_wr_accept && !w_wr_oor) begin
      r_wb_x    <= wr_x;
      r_wb_y    <= wr_y;
      r_wb_data <= wr_data;
    end
  end

  assign wr_ready      = w_wr_ready;
  assign wr_drop       = r_wr_drop;
  assign overrun       = r_overrun;
  assign read          = r_read;
  assign write         = r_write;
  assign mem_addr_x    = r_addr_x;
  assign mem_addr_y    = r_addr_y;
  assign data_to_write = r_dtw;
  assign pix_valid     = r_pix_valid;
  assign pix_data      = r_pix_data;

endmodule

// File: tb/tb_sram_scheduler.sv
// Testbench for sram_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model that tracks each SRAM operation by its age in cycles.
module tb_sram_scheduler;

  localparam int XMAX = 400;
  localparam int YMAX = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_req;
  logic [8:0]  pix_x, pix_y;
  logic [5:0]  pix_data;
  logic        pix_valid;
  logic        wr_valid;
  logic [8:0]  wr_x, wr_y;
  logic [5:0]  wr_data;
  logic        wr_ready, wr_drop, overrun, read, write;
  logic [8:0]  mem_addr_x, mem_addr_y;
  logic [15:0] data_to_write;
  logic [15:0] data_in;

  always #5 clk = ~clk;

  sram_scheduler #(.XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk(clk), .rst(rst),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_drop(wr_drop), .overrun(overrun),
    .read(read), .write(write),
    .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
    .data_to_write(data_to_write), .data_in(data_in)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit oor(input logic [8:0] x, input logic [8:0] y);
    return (int'(x) >= XMAX) || (int'(y) >= YMAX);
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: an SRAM operation starts in an idle decision cycle s.
  // Read: read strobe in s+1, s+2; data sampled at end of s+2; pix_valid in
  // s+3, which is idle again. Write: setup s+1, strobe s+2, hold s+3; the
  // buffer frees at end of s+3; s+4 is idle.
  // ---------------------------------------------------------------------
  typedef enum {OP_NONE, OP_RD, OP_WR} op_e;
  op_e         m_op = OP_NONE;
  int          m_age = 0;
  bit          m_valid = 1'b0;
  bit          m_pend, m_rd_oor, m_wb_full, m_ovr;
  logic [8:0]  m_pend_x, m_pend_y, m_wb_x, m_wb_y;
  logic [5:0]  m_wb_d;
  logic        e_read, e_write, e_pv, e_drop, e_win;
  logic [5:0]  e_pix_data;
  logic [8:0]  e_ax, e_ay;
  logic [15:0] e_dtw;
  bit          m_idle_now, m_accept;
  logic [8:0]  m_sx, m_sy;

  // Compare DUT against the model's view of this cycle, then advance the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("read", 16'(read), 16'(e_read));
      check("write", 16'(write), 16'(e_write));
      check("read_write_overlap", 16'(read & write), 16'd0);
      check("pix_valid", 16'(pix_valid), 16'(e_pv));
      check("wr_drop", 16'(wr_drop), 16'(e_drop));
      check("overrun", 16'(overrun), 16'(m_ovr));
      check("wr_ready", 16'(wr_ready), 16'(!m_wb_full && !rst));
      check("data_to_write", data_to_write, e_dtw);
      if (e_pv) check("pix_data", 16'(pix_data), 16'(e_pix_data));
      if (e_read || e_win) begin
        check("mem_addr_x", 16'(mem_addr_x), 16'(e_ax));
        check("mem_addr_y", 16'(mem_addr_y), 16'(e_ay));
      end
    end

    if (rst) begin
      m_op = OP_NONE; m_age = 0; m_pend = 0; m_wb_full = 0; m_ovr = 0; m_rd_oor = 0;
      e_read = 0; e_write = 0; e_pv = 0; e_drop = 0; e_win = 0;
      e_pix_data = 0; e_ax = 0; e_ay = 0; e_dtw = 0;
    end else begin
      m_idle_now = (m_op == OP_NONE);
      m_accept   = wr_valid && !m_wb_full;
      e_read = 0; e_write = 0; e_pv = 0; e_drop = 0; e_win = 0; e_dtw = 0;
      if (m_idle_now) begin
        if (m_pend || pix_req) begin
          if (m_pend) begin
            m_sx = m_pend_x; m_sy = m_pend_y;
            if (pix_req) m_ovr = 1;
          end else begin
            m_sx = pix_x; m_sy = pix_y;
          end
          m_pend = 0; m_op = OP_RD; m_age = 0; m_rd_oor = oor(m_sx, m_sy);
          e_read = !m_rd_oor; e_ax = m_sx; e_ay = m_sy;
        end else if (m_wb_full) begin
          m_op = OP_WR; m_age = 0; e_win = 1;
          e_dtw = {10'b0, m_wb_d}; e_ax = m_wb_x; e_ay = m_wb_y;
        end
      end else begin
        if (pix_req) begin
          if (m_pend) m_ovr = 1;
          else begin m_pend = 1; m_pend_x = pix_x; m_pend_y = pix_y; end
        end
        if (m_op == OP_RD) begin
          if (m_age == 1) e_read = !m_rd_oor;
          else begin
            e_pv = 1; e_pix_data = m_rd_oor ? 6'd0 : data_in[5:0]; m_op = OP_NONE;
          end
        end else begin
          if (m_age < 3) begin
            e_win = 1; e_dtw = {10'b0, m_wb_d}; e_write = (m_age == 1);
          end else begin
            m_wb_full = 0; m_op = OP_NONE;
          end
        end
      end
      if (m_op != OP_NONE) m_age++;
      if (m_accept) begin
        if (oor(wr_x, wr_y)) e_drop = 1;
        else begin m_wb_full = 1; m_wb_x = wr_x; m_wb_y = wr_y; m_wb_d = wr_data; end
      end
    end
    m_valid = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_req = 0; wr_valid = 0; rst = 0;
    repeat (n) step();
  endtask

  function automatic logic [8:0] rnd_coord(input int lim);
    case ($urandom_range(0, 9))
      7:       return 9'(lim - 1);
      8:       return 9'(lim);
      9:       return 9'($urandom_range(0, 511));
      default: return 9'($urandom_range(0, lim - 1));
    endcase
  endfunction

  int cnt_a, cnt_b, first_a, first_b, overlap;

  initial begin
    rst = 1; pix_req = 0; wr_valid = 0; pix_x = 0; pix_y = 0;
    wr_x = 0; wr_y = 0; wr_data = 0; data_in = 0;
    step(); step();
    rst = 0;
    @(negedge clk);
    check("reset_read", 16'(read), 16'd0);
    check("reset_pix_valid", 16'(pix_valid), 16'd0);
    check("reset_wr_ready", 16'(wr_ready), 16'd1);
    check("reset_addr", 16'({mem_addr_x[6:0], mem_addr_y}), 16'd0);

    // Idle read at (10,20)
    idle(6);
    data_in = 16'h002A; pix_req = 1; pix_x = 10; pix_y = 20;
    step(); pix_req = 0; @(negedge clk);
    check("rd_n1_read", 16'(read), 16'd1);
    check("rd_n1_addr_x", 16'(mem_addr_x), 16'd10);
    check("rd_n1_addr_y", 16'(mem_addr_y), 16'd20);
    step(); @(negedge clk);
    check("rd_n2_read", 16'(read), 16'd1);
    check("rd_n2_pv", 16'(pix_valid), 16'd0);
    step(); @(negedge clk);
    check("rd_n3_read", 16'(read), 16'd0);
    check("rd_n3_pv", 16'(pix_valid), 16'd1);
    check("rd_n3_data", 16'(pix_data), 16'h002A);

    // Write at the far corner (399,299)
    idle(6);
    wr_valid = 1; wr_x = 399; wr_y = 299; wr_data = 6'h15;
    @(negedge clk);
    check("wr_n0_ready", 16'(wr_ready), 16'd1);
    cnt_a = 0;
    for (int k = 1; k <= 6; k++) begin
      step(); wr_valid = 0; @(negedge clk);
      check($sformatf("wr_n%0d_ready", k), 16'(wr_ready), 16'(k >= 5));
      if (write) begin
        cnt_a++;
        check("wr_pulse_cycle", 16'(k), 16'd3);
        check("wr_addr_x", 16'(mem_addr_x), 16'd399);
        check("wr_addr_y", 16'(mem_addr_y), 16'd299);
        check("wr_data", data_to_write, 16'h0015);
      end
    end
    check("wr_pulse_count", 16'(cnt_a), 16'd1);

    // Collision: read and write offered in the same idle cycle
    idle(6);
    data_in = 16'h0011; pix_req = 1; pix_x = 5; pix_y = 6;
    wr_valid = 1; wr_x = 7; wr_y = 8; wr_data = 6'h3F;
    cnt_a = 0; cnt_b = 0; first_a = 0; first_b = 0; overlap = 0;
    for (int k = 1; k <= 9; k++) begin
      step(); pix_req = 0; wr_valid = 0; @(negedge clk);
      if (read)  begin cnt_a++; if (first_a == 0) first_a = k; end
      if (write) begin cnt_b++; if (first_b == 0) first_b = k; end
      if (read && write) overlap++;
      if (k == 3) check("col_pix_data", 16'(pix_data), 16'h0011);
    end
    check("col_read_first", 16'(first_a), 16'd1);
    check("col_read_count", 16'(cnt_a), 16'd2);
    check("col_write_first", 16'(first_b), 16'd5);
    check("col_write_count", 16'(cnt_b), 16'd1);
    check("col_overlap", 16'(overlap), 16'd0);

    // Out-of-range write (400,0)
    idle(6);
    wr_valid = 1; wr_x = 400; wr_y = 0; wr_data = 6'h2B;
    cnt_b = 0;
    for (int k = 1; k <= 6; k++) begin
      step(); wr_valid = 0; @(negedge clk);
      check($sformatf("oorw_n%0d_drop", k), 16'(wr_drop), 16'(k == 1));
      check($sformatf("oorw_n%0d_ready", k), 16'(wr_ready), 16'd1);
      if (write) cnt_b++;
    end
    check("oorw_write_count", 16'(cnt_b), 16'd0);

    // Out-of-range read (0,300)
    idle(6);
    data_in = 16'h003F; pix_req = 1; pix_x = 0; pix_y = 300;
    for (int k = 1; k <= 4; k++) begin
      step(); pix_req = 0; @(negedge clk);
      check($sformatf("oorr_n%0d_read", k), 16'(read), 16'd0);
      check($sformatf("oorr_n%0d_pv", k), 16'(pix_valid), 16'(k == 3));
      if (k == 3) check("oorr_pix_data", 16'(pix_data), 16'd0);
    end

    // Reset asserted during the write strobe
    idle(6);
    wr_valid = 1; wr_x = 33; wr_y = 44; wr_data = 6'h09;
    cnt_b = 0;
    for (int k = 1; k <= 10; k++) begin
      step(); wr_valid = 0; rst = (k == 3); @(negedge clk);
      if (k == 3) begin
        check("rstw_pulse_seen", 16'(write), 16'd1);
        check("rstw_ready_in_rst", 16'(wr_ready), 16'd0);
      end
      if (k == 4) begin
        check("rstw_write", 16'(write), 16'd0);
        check("rstw_dtw", data_to_write, 16'd0);
        check("rstw_addr_x", 16'(mem_addr_x), 16'd0);
        check("rstw_read", 16'(read), 16'd0);
        check("rstw_ready", 16'(wr_ready), 16'd1);
        check("rstw_overrun", 16'(overrun), 16'd0);
      end
      if (k >= 4 && write) cnt_b++;
    end
    check("rstw_no_restart", 16'(cnt_b), 16'd0);

    // Overrun: three back-to-back requests from idle
    idle(6);
    data_in = 16'h0007; cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      pix_req = (k < 3); pix_x = 9'(k + 1); pix_y = 9'(k + 1);
      @(negedge clk);
      if (k == 2) check("ov_before", 16'(overrun), 16'd0);
      if (k == 3) check("ov_after", 16'(overrun), 16'd1);
      if (k == 4) check("ov_second_addr", 16'(mem_addr_x), 16'd2);
      if (pix_valid) cnt_a++;
    end
    check("ov_pv_count", 16'(cnt_a), 16'd2);

    // Randomized traffic, checked by the model every cycle
    idle(2);
    for (int c = 0; c < 5000; c++) begin
      step();
      rst      = ($urandom_range(0, 249) == 0);
      pix_req  = ($urandom_range(0, 3) == 0);
      pix_x    = rnd_coord(XMAX);
      pix_y    = rnd_coord(YMAX);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_x     = rnd_coord(XMAX);
      wr_y     = rnd_coord(YMAX);
      wr_data  = 6'($urandom);
      data_in  = 16'($urandom);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_scheduler.md
SRAM_SCHEDULER -- requirements
Module: sram_scheduler

Interface
REQ-001 Parameter XMAX, default 400: visible framebuffer width in cells.
REQ-002 Parameter YMAX, default 300: visible framebuffer height in cells.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pix_req  input  1  one-cycle pulse requesting a read of one pixel cell.
REQ-006 pix_x / pix_y  input  9 each  read coordinates, sampled only in the pix_req cycle.
REQ-007 pix_data  output  6  read cell value, valid only while pix_valid=1.
REQ-008 pix_valid  output  1  one-cycle pulse marking pix_data valid.
REQ-009 wr_valid  input  1  write offer from game logic.
REQ-010 wr_x / wr_y  input  9 each  write coordinates.
REQ-011 wr_data  input  6  write cell value.
REQ-012 wr_ready  output  1  write buffer empty; a transfer occurs on a rising edge with wr_valid=1 and wr_ready=1.
REQ-013 wr_drop  output  1  one-cycle pulse: an accepted write was out of range and discarded.
REQ-014 overrun  output  1  sticky flag: a pix_req was lost.
REQ-015 read / write  output  1 each  strobes to the SRAM controller, active-high.
REQ-016 mem_addr_x / mem_addr_y  output  9 each  cell address to the SRAM controller.
REQ-017 data_to_write  output  16  write data to the SRAM controller.
REQ-018 data_in  input  16  SRAM data bus as seen on read; only bits [5:0] used.

Function
REQ-019 Registered FSM states: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD; read, write, address and data_to_write are registered outputs.
REQ-020 One-deep read-request latch (rd_pend plus coordinates) and one-deep write buffer (wb_full, wb_x, wb_y, wb_data).
REQ-021 pix_req in any cycle sets rd_pend and captures pix_x/pix_y, unless the FSM is in IDLE, in which case it goes directly to RD_SETUP.
REQ-022 pix_req while rd_pend=1 sets overrun; the new request is discarded and the pending one is kept.
REQ-023 Read sequence: RD_SETUP (read=1, address driven) -> RD_SAMPLE (read=1) -> IDLE; data_in[5:0] captured at the RD_SAMPLE->IDLE edge; pix_valid=1 in the following cycle.
REQ-024 Read latency from an idle pix_req cycle N: read=1 in cycles N+1 and N+2, pix_valid=1 in cycle N+3; the worst case (arriving during a write) is 6 cycles.
REQ-025 Read with pix_x>=XMAX or pix_y>=YMAX: same state sequence and latency, but read stays 0 and pix_data=0.
REQ-026 wr_ready = ~wb_full & ~rst; an accepted transfer sets wb_full on the same edge.
REQ-027 Priority in IDLE: a read (pix_req or rd_pend) beats a buffered write; a simultaneous pix_req and wr_valid gives RD_SETUP plus a write-buffer load.
REQ-028 Write sequence, only from IDLE with wb_full=1 and no read pending:
  - WR_SETUP: address and data_to_write={10'b0,wb_data} driven, write=0.
  - WR_PULSE: write=1.
  - WR_HOLD: write=0, address and data still held.
  - Then IDLE; wb_full clears on the WR_HOLD->IDLE edge.
REQ-029 A write sequence is never preempted; a pix_req arriving during it latches and is served immediately after WR_HOLD.
REQ-030 Accepted write with wr_x>=XMAX or wr_y>=YMAX: not buffered (wr_ready stays 1), wr_drop=1 in the next cycle, no SRAM cycle.
REQ-031 read and write are never 1 in the same cycle; data_to_write=0 outside the write states; the address holds its last value in IDLE.
REQ-032 Out-of-range checks are unsigned 9-bit compares; coordinates are never wrapped or clipped.

Reset
REQ-033 On an edge with rst=1, from any state and mid-sequence:
  - State goes to IDLE.
  - read, write, pix_valid, wr_drop, overrun, rd_pend and wb_full go to 0.
  - pix_data, mem_addr_x, mem_addr_y and data_to_write go to 0.
REQ-034 Any in-flight SRAM cycle is aborted without completing; wr_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-035 Idle read: pix_req at (10,20), data_in=16'h002A -> read=1 for 2 cycles at addr (10,20), pix_valid in cycle N+3, pix_data=6'h2A.
REQ-036 Write: wr_valid (399,299,6'h15) -> wr_ready falls; write=1 for exactly 1 cycle at (399,299), data_to_write=16'h0015; wr_ready high 4 cycles after acceptance.
REQ-037 Collision: pix_req and wr_valid in the same idle cycle -> read sequence first, then the write sequence; read and write never overlap.
REQ-038 Out of range: write at (400,0) -> wr_drop pulse, no write strobe; read at (0,300) -> read stays 0, pix_valid in cycle N+3, pix_data=0.
REQ-039 Overrun: three pix_req on consecutive cycles from IDLE -> the third sets overrun; exactly two pix_valid pulses.
REQ-040 Reset during WR_PULSE -> write=0 on the next edge, wb_full=0, all outputs 0, wr_ready=1 after deassertion.
